hbridge_guard: RTL
==================

# hbridge_guard

Output protection stage between the sine-PWM modulator and the H-bridge driver pins. It takes the modulator's raw complementary bridge commands and inserts a programmable dead time on every polarity change, so both bridge legs are never driven together. It also runs an overcurrent trip from the bridge current ADC and owns the EN1/EN2 enables. The modulator's OUT1/OUT2 connect to PWM_A/PWM_B; DRV1/DRV2/EN1/EN2 go to the pins.

## Interface
- DEAD_CYCLES, 25: clock periods both legs are held low on any polarity change; legal range ≥1.
- OC_COUNT, 4: consecutive over-threshold ADC samples required to trip; legal range ≥1.
- FAULT_HOLD, 50000: minimum clock periods spent in FAULT before a clear is accepted.
- ADC_BITS, 12: width of ADC and ADC_CMP.

Ports:
- CLK  in  1  system clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  bridge enable request (level).
- PWM_A  in  1  modulator leg-A command (OUT1).
- PWM_B  in  1  modulator leg-B command (OUT2).
- ADC  in  ADC_BITS  bridge current sample, unsigned.
- ADC_VALID  in  1  one-cycle strobe; ADC is valid this cycle.
- ADC_CMP  in  ADC_BITS  overcurrent threshold, unsigned.
- FAULT_CLR  in  1  fault clear request (level, sampled).
- DRV1  out  1  leg-A drive.
- DRV2  out  1  leg-B drive.
- EN1  out  1  bridge enable, leg A.
- EN2  out  1  bridge enable, leg B.
- FAULT  out  1  overcurrent fault latched.
- STATE  out  3  FSM state code for debug: OFF=0, IDLE=1, DEAD=2, DRIVE_A=3, DRIVE_B=4, FAULT=5.

## Operation
- Command decode: A = PWM_A & !PWM_B; B = !PWM_A & PWM_B; both low or both high = NONE. Both-high is illegal and treated as NONE.
- OFF: DRV1=DRV2=0, EN1=EN2=0. ENABLE=1 moves the FSM to DEAD with the dead counter loaded to DEAD_CYCLES.
- DEAD: EN=1, DRV1=DRV2=0. The counter decrements every cycle and is not restarted by command changes while counting. At expiry the FSM goes to DRIVE_A for A, DRIVE_B for B, or IDLE for NONE, based on the command sampled that cycle.
- IDLE: EN=1, DRV low. Command A or B moves the FSM to DEAD; it never drives directly.
- DRIVE_A: DRV1=1. Any command other than A moves the FSM to DEAD, with the counter reloaded.
- DRIVE_B: DRV2=1, handled symmetrically to DRIVE_A.
- ENABLE=0 in any non-FAULT state moves the FSM to OFF on the next edge.
- Overcurrent counter:
  - On ADC_VALID with ADC > ADC_CMP (unsigned), the counter increments, saturating at OC_COUNT.
  - On ADC_VALID with ADC ≤ ADC_CMP, the counter clears.
  - With no strobe, the counter holds.
  - The counter is active in every state except FAULT.
- Trip: when the counter reaches OC_COUNT, the FSM enters FAULT on the next edge from any state. FAULT takes priority over ENABLE and over the command.
- FAULT:
  - Outputs: DRV low, EN low, FAULT=1.
  - On entry, the hold counter loads FAULT_HOLD and the OC counter clears.
  - FAULT_CLR is ignored until the hold counter reaches 0.
  - Once the hold counter is 0, FAULT_CLR=1 moves the FSM to OFF and sets FAULT=0.
  - ADC strobes are ignored in FAULT.
- Widths: the dead counter is clog2(DEAD_CYCLES+1) bits; the hold counter is clog2(FAULT_HOLD+1) bits.

## Timing
- Reset values: state OFF; DRV1, DRV2, EN1, EN2 and FAULT all 0; STATE=0; all counters 0. Reset in mid-drive or mid-fault forces these values on the next edge.
- All outputs are registered decodes of the state register, with no combinational path from inputs.
- Polarity change: a changed command sampled at edge k drops the old DRV after edge k. The new DRV rises after edge k+DEAD_CYCLES. Both legs are low for exactly DEAD_CYCLES periods.
- Enable: ENABLE sampled high at edge k in OFF asserts EN after edge k. The first DRV is asserted no earlier than edge k+DEAD_CYCLES.
- Trip: the OC_COUNT-th qualifying strobe at edge k drops DRV, EN and sets FAULT after edge k+1.
- Fault clear: FAULT_CLR is honoured only from edge (entry+FAULT_HOLD) onward.
- Simultaneous trip and command change: the trip wins.
- Simultaneous ENABLE=0 and DEAD expiry: the FSM goes to OFF.

## Test plan
- Polarity change: DEAD_CYCLES=25, ENABLE=1, PWM_A=1 steady, then switch to PWM_B=1 at edge k → DRV1 low after edge k, DRV2 high after edge k+25, never both high.
- Command glitch during dead time: A→NONE→A within 5 cycles → full 25-cycle DEAD, then DRIVE_A; dead counter not restarted.
- Illegal command: PWM_A=PWM_B=1 while in DRIVE_A → DEAD, then IDLE; DRV1=DRV2=0.
- Overcurrent trip: ADC_CMP=2000, OC_COUNT=4, ADC=2001 for 3 strobes, then 1999, then 2001 for 4 strobes → no trip after the first 3; FAULT=1 and EN low one cycle after the 4th of the final run.
- Fault hold: FAULT_HOLD=100, FAULT_CLR held high from entry → FAULT stays 1 for 100 cycles, then OFF; ENABLE=1 → DEAD, then drive.
- Reset mid-fault and ENABLE=0 mid-DRIVE_B → all outputs 0, STATE=0 on the next edge.

Source files
------------

// File: rtl/hbridge_guard.sv
// H-bridge output guard: dead-time insertion between leg commands, overcurrent trip
// with a minimum fault hold, and ownership of the bridge enables.
module hbridge_guard #(
    parameter int unsigned DEAD_CYCLES = 25,
    parameter int unsigned OC_COUNT    = 4,
    parameter int unsigned FAULT_HOLD  = 50000,
    parameter int unsigned ADC_BITS    = 12
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                pwm_a_i,
    input  logic                pwm_b_i,
    input  logic [ADC_BITS-1:0] adc_i,
    input  logic                adc_valid_i,
    input  logic [ADC_BITS-1:0] adc_cmp_i,
    input  logic                fault_clr_i,
    output logic                drv1_o,
    output logic                drv2_o,
    output logic                en1_o,
    output logic                en2_o,
    output logic                fault_o,
    output logic [2:0]          state_o
);

    localparam int unsigned DeadW = $clog2(DEAD_CYCLES + 1);
    localparam int unsigned OcW   = $clog2(OC_COUNT + 1);
    localparam int unsigned HoldW = (FAULT_HOLD > 0) ? $clog2(FAULT_HOLD + 1) : 1;

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StIdle   = 3'd1,
        StDead   = 3'd2,
        StDriveA = 3'd3,
        StDriveB = 3'd4,
        StFault  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [DeadW-1:0]   dead_q, dead_d;
    logic [OcW-1:0]     oc_q, oc_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               drv1_q, drv2_q, en_q, fault_q;

    logic cmd_a, cmd_b, trip, hold_done;

    assign cmd_a = pwm_a_i & ~pwm_b_i;
    assign cmd_b = ~pwm_a_i & pwm_b_i;
    assign trip  = (oc_q == OcW'(OC_COUNT));
    // The hold counter hits zero on this edge, so the clear lands exactly FAULT_HOLD edges in.
    assign hold_done = (hold_q <= HoldW'(1));

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        oc_d    = oc_q;
        hold_d  = hold_q;

        if (state_q != StFault && adc_valid_i) begin
            if (adc_i > adc_cmp_i) begin
                oc_d = trip ? oc_q : oc_q + OcW'(1);
            end else begin
                oc_d = '0;
            end
        end
        if (state_q == StFault && hold_q != '0) begin
            hold_d = hold_q - HoldW'(1);
        end
        if (state_q == StDead && dead_q != '0) begin
            dead_d = dead_q - DeadW'(1);
        end

        if (trip && state_q != StFault) begin
            state_d = StFault;
            hold_d  = HoldW'(FAULT_HOLD);
            oc_d    = '0;
        end else if (state_q == StFault) begin
            if (hold_done && fault_clr_i) begin
                state_d = StOff;
            end
        end else if (state_q == StOff) begin
            if (enable_i) begin
                state_d = StDead;
                dead_d  = DeadW'(DEAD_CYCLES);
            end
        end else if (!enable_i) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_a || cmd_b) begin
                        state_d = StDead;
                        dead_d  = DeadW'(DEAD_CYCLES);
                    end
                end
                StDead: begin
                    // Command changes while counting never restart the dead time.
                    if (dead_q <= DeadW'(1)) begin
                        state_d = cmd_a ? StDriveA : (cmd_b ? StDriveB : StIdle);
                    end
                end
                StDriveA: begin
                    if (!cmd_a) begin
                        state_d = StDead;
                        dead_d  = DeadW'(DEAD_CYCLES);
                    end
                end
                StDriveB: begin
                    if (!cmd_b) begin
                        state_d = StDead;
                        dead_d  = DeadW'(DEAD_CYCLES);
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StOff;
            dead_q  <= '0;
            oc_q    <= '0;
            hold_q  <= '0;
            drv1_q  <= 1'b0;
            drv2_q  <= 1'b0;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            oc_q    <= oc_d;
            hold_q  <= hold_d;
            drv1_q  <= (state_d == StDriveA);
            drv2_q  <= (state_d == StDriveB);
            en_q    <= (state_d == StIdle) || (state_d == StDead) ||
                       (state_d == StDriveA) || (state_d == StDriveB);
            fault_q <= (state_d == StFault);
        end
    end

    assign drv1_o  = drv1_q;
    assign drv2_o  = drv2_q;
    assign en1_o   = en_q;
    assign en2_o   = en_q;
    assign fault_o = fault_q;
    assign state_o = state_q;

endmodule
